// File: rtl/led_pwm_bank.sv
// ----------------------------------------------------------------------------
// led_pwm_bank
//
// This is a memory-mapped bank of PWM channels for the board LEDs. All
// channels share one prescaler and one PWM period counter. Each channel
// compares the period counter against its own ACTIVE duty register.
//
// A new duty value never takes effect in the middle of a period. The CPU
// writes a TARGET register, and each channel copies TARGET into ACTIVE on
// the last clock of a period. With the fade option built in and enabled,
// ACTIVE instead moves one step toward TARGET per period.
//
// Register map (write and read):
//   0 .. NUM_CH-1 : TARGET[i], DUTY_W bits
//   NUM_CH        : CTRL, bit0 EN, bit1 FADE
//   other         : writes ignored, reads return 0
//
// Optional feature (macro LED_PWM_FADE_EN):
//   defined   : CTRL bit1 is stored and ACTIVE ramps by one step per period.
//   undefined : CTRL bit1 is ignored and always reads 0. ACTIVE jumps
//               straight to TARGET.
//
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   wr_en      : register write strobe
//   wr_addr    : write register index
//   wr_data    : write data, only the low bits are used
//   rd_addr    : read register index
//   rd_data    : registered read data, one clock of latency
//   period_end : one-clock pulse on the last clock of each PWM period
//   pwm_out    : per-channel LED drive, polarity set by ACTIVE_LOW
// ----------------------------------------------------------------------------
module led_pwm_bank #(
    parameter int NUM_CH     = 4,
    parameter int DUTY_W     = 8,
    parameter int PRESCALE   = 12,
    parameter int ACTIVE_LOW = 1,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              period_end,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam int                PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST    = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]   PS_ONE     = PS_W'(1);
    localparam logic [DUTY_W-1:0] CNT_LAST   = DUTY_W'((1 << DUTY_W) - 2);
    localparam logic [DUTY_W-1:0] DUTY_ONE   = DUTY_W'(1);
    localparam logic [ADDR_W-1:0] CTRL_ADDR  = ADDR_W'(NUM_CH);
    localparam logic [NUM_CH-1:0] IDLE_LEVEL = {NUM_CH{(ACTIVE_LOW != 0)}};

    logic [PS_W-1:0]   psCount;
    logic              tick;
    logic [DUTY_W-1:0] pwmCount;
    logic              periodEnd;
    logic [DUTY_W-1:0] target     [NUM_CH];
    logic [DUTY_W-1:0] active     [NUM_CH];
    logic [DUTY_W-1:0] activeNext [NUM_CH];
    logic              ctrlEn;
`ifdef LED_PWM_FADE_EN
    logic              ctrlFade;
`endif
    logic [NUM_CH-1:0] litNext;
    logic [NUM_CH-1:0] pwmReg;
    logic [31:0]       rdNext;
    logic              unusedBits;

    assign tick       = (psCount == PS_LAST);
    assign periodEnd  = tick && (pwmCount == CNT_LAST);
    assign period_end = periodEnd;
    assign pwm_out    = pwmReg;
    assign unusedBits = ^wr_data[31:DUTY_W];

    // The prescaler divides clk down to the PWM tick. It counts from 0 up
    // to PRESCALE-1, and tick is high on the clock where it holds the last
    // value. With PRESCALE=1 the register stays at 0, so tick is high on
    // every clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psCount <= '0;
        end else if (tick) begin
            psCount <= '0;
        end else begin
            psCount <= psCount + PS_ONE;
        end
    end

    // The period counter steps once per tick. It stops one short of the
    // all-ones value, so a period is MAX ticks long. A duty of MAX therefore
    // keeps the LED lit for the whole period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwmCount <= '0;
        end else if (tick) begin
            if (pwmCount == CNT_LAST) begin
                pwmCount <= '0;
            end else begin
                pwmCount <= pwmCount + DUTY_ONE;
            end
        end
    end

    // These are the CPU-visible registers. A write that lands on the same
    // clock as period_end still updates TARGET. The ACTIVE update on that
    // edge sees the old TARGET, because both registers are sampled on the
    // same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                target[i] <= '0;
            end
            ctrlEn <= 1'b0;
`ifdef LED_PWM_FADE_EN
            ctrlFade <= 1'b0;
`endif
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    target[i] <= wr_data[DUTY_W-1:0];
                end
            end
            if (wr_addr == CTRL_ADDR) begin
                ctrlEn <= wr_data[0];
`ifdef LED_PWM_FADE_EN
                ctrlFade <= wr_data[1];
`endif
            end
        end
    end

    // This block computes the duty that each channel adopts at the next
    // period boundary. Normally that is simply TARGET. While fading, ACTIVE
    // moves one step toward TARGET and stays put once the two are equal.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            activeNext[i] = target[i];
`ifdef LED_PWM_FADE_EN
            if (ctrlFade) begin
                if (active[i] < target[i]) begin
                    activeNext[i] = active[i] + DUTY_ONE;
                end else if (active[i] > target[i]) begin
                    activeNext[i] = active[i] - DUTY_ONE;
                end
            end
`endif
        end
    end

    // ACTIVE changes only on the last clock of a period. The comparator
    // therefore always sees one consistent duty for a whole period, which
    // keeps the output free of glitches. ACTIVE keeps updating even while
    // EN is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                active[i] <= '0;
            end
        end else if (periodEnd) begin
            for (int i = 0; i < NUM_CH; i++) begin
                active[i] <= activeNext[i];
            end
        end
    end

    // A channel is lit while the period counter is below its duty and the
    // bank is enabled. Clearing EN forces every output idle on the next clock.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            litNext[i] = ctrlEn && (pwmCount < active[i]);
        end
    end

    // The outputs are registered so the LED pads see clean edges. The
    // polarity flip for active-low pads is folded into the register, which
    // makes the reset value "all idle".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwmReg <= IDLE_LEVEL;
        end else begin
            pwmReg <= litNext ^ IDLE_LEVEL;
        end
    end

    // This is the read mux. Unmapped addresses and unused bits read as 0.
    // It looks at register contents before this clock's write, so a
    // same-cycle read of a written address returns the old value.
    always_comb begin
        rdNext = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rdNext[DUTY_W-1:0] = target[i];
            end
        end
        if (rd_addr == CTRL_ADDR) begin
            rdNext[0] = ctrlEn;
`ifdef LED_PWM_FADE_EN
            rdNext[1] = ctrlFade;
`endif
        end
    end

    // Read data is registered, which gives one clock of latency from rd_addr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rdNext;
        end
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// ----------------------------------------------------------------------------
// tb_led_pwm_bank
//
// Self-checking bench for led_pwm_bank, built with DUTY_W=4, PRESCALE=2,
// ACTIVE_LOW=1 and NUM_CH=4. With these values one PWM period is 30 clocks.
//
// The reference model works in terms of clock position within a period
// rather than separate counters. It tracks TARGET, ACTIVE, EN and FADE as
// plain integers. A compare process checks pwm_out, period_end and rd_data
// against the model on every falling edge. Directed measurements of
// low-time per period pin the model against hand-computed values.
// ----------------------------------------------------------------------------
module tb_led_pwm_bank;

    localparam int NUM_CH     = 4;
    localparam int DUTY_W     = 4;
    localparam int PRESCALE   = 2;
    localparam int ACTIVE_LOW = 1;
    localparam int ADDR_W     = 3;
    localparam int MAXD       = (1 << DUTY_W) - 1;
    localparam int PERIOD     = MAXD * PRESCALE;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              period_end;
    logic [NUM_CH-1:0] pwm_out;

    int assertCount = 0;
    int failCount   = 0;

    int          modelTarget [NUM_CH];
    int          modelActive [NUM_CH];
    bit          modelEn   = 1'b0;
    bit          modelFade = 1'b0;
    int          modelCyc  = 0;
    int          modelPos;
    int          modelCnt;
    logic [3:0]  expPwm = 4'hF;
    logic [31:0] expRd  = 32'd0;
    logic [31:0] expPe;

    int lowCnt [NUM_CH];
    int waitCount;

    led_pwm_bank #(
        .NUM_CH     (NUM_CH),
        .DUTY_W     (DUTY_W),
        .PRESCALE   (PRESCALE),
        .ACTIVE_LOW (ACTIVE_LOW),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .period_end (period_end),
        .pwm_out    (pwm_out)
    );

    // The free-running system clock has a 10-time-unit period.
    always #5 clk = ~clk;

    // This task records one comparison and prints a FAIL line when the
    // observed value differs from the expected one.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // This task drives the bus inputs immediately. Callers invoke it from
    // a falling edge.
    task automatic applyStimulus(input logic en, input logic [ADDR_W-1:0] waddr,
                                 input logic [31:0] wdata, input logic [ADDR_W-1:0] raddr);
        wr_en   = en;
        wr_addr = waddr;
        wr_data = wdata;
        rd_addr = raddr;
    endtask

    // This task performs a single one-clock register write. It starts and
    // finishes on a falling edge.
    task automatic writeReg(input logic [ADDR_W-1:0] waddr, input logic [31:0] wdata);
        @(negedge clk);
        applyStimulus(1'b1, waddr, wdata, rd_addr);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // This task waits, with a bound, for a falling edge where period_end is
    // high. The number of extra edges waited is returned in n.
    task automatic waitPeriodEnd(output int n);
        n = 0;
        @(negedge clk);
        while (period_end !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("period_end_wait", {31'd0, period_end}, 32'd1);
    endtask

    // This task counts lit (low) clocks per channel over one output period.
    // With sync set, it first aligns to the period that follows the next
    // boundary. Without sync, it continues from where the previous call
    // stopped.
    task automatic measurePeriod(input bit sync);
        int n;
        if (sync) begin
            waitPeriodEnd(n);
            @(negedge clk);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            lowCnt[ch] = 0;
        end
        repeat (PERIOD) begin
            @(negedge clk);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (pwm_out[ch] == 1'b0) begin
                    lowCnt[ch]++;
                end
            end
        end
    endtask

    // This function gives the register value the model expects at an address.
    function automatic logic [31:0] modelRead(input logic [ADDR_W-1:0] a);
        if (int'(a) < NUM_CH) begin
            return 32'(modelTarget[int'(a)]);
        end
        if (int'(a) == NUM_CH) begin
            return {30'd0, modelFade, modelEn};
        end
        return 32'd0;
    endfunction

    // This is the behavioural model, stepped once per rising edge. The
    // position within a 30-clock period determines the counter value,
    // and the last position marks a boundary. The lit state is formed from
    // values before the edge. The boundary update runs before the write,
    // so a coincident write is not seen by that boundary.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                modelTarget[i] = 0;
                modelActive[i] = 0;
            end
            modelEn   = 1'b0;
            modelFade = 1'b0;
            modelCyc  = 0;
            expPwm    = 4'hF;
            expRd     = 32'd0;
        end else begin
            modelPos = modelCyc % PERIOD;
            modelCnt = modelPos / PRESCALE;
            expRd    = modelRead(rd_addr);
            for (int i = 0; i < NUM_CH; i++) begin
                expPwm[i] = !(modelEn && (modelCnt < modelActive[i]));
            end
            if (modelPos == PERIOD - 1) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (modelFade) begin
                        if (modelTarget[i] > modelActive[i]) begin
                            modelActive[i] = modelActive[i] + 1;
                        end else if (modelTarget[i] < modelActive[i]) begin
                            modelActive[i] = modelActive[i] - 1;
                        end
                    end else begin
                        modelActive[i] = modelTarget[i];
                    end
                end
            end
            if (wr_en) begin
                if (int'(wr_addr) < NUM_CH) begin
                    modelTarget[int'(wr_addr)] = int'(wr_data[DUTY_W-1:0]);
                end else if (int'(wr_addr) == NUM_CH) begin
                    modelEn = wr_data[0];
`ifdef LED_PWM_FADE_EN
                    modelFade = wr_data[1];
`endif
                end
            end
            modelCyc++;
        end
    end

    // This process compares every output against the model on each falling
    // edge, which is well away from the edge where the DUT updates.
    always @(negedge clk) begin
        expPe = (!reset && (modelCyc % PERIOD == PERIOD - 1)) ? 32'd1 : 32'd0;
        checkOutput("pwm_out", {28'd0, pwm_out}, {28'd0, expPwm});
        checkOutput("rd_data", rd_data, expRd);
        checkOutput("period_end", {31'd0, period_end}, expPe);
    end

    // This is the directed and random stimulus sequence.
    initial begin
        int fadeUp [5];
        int fadeDown [3];
`ifdef LED_PWM_FADE_EN
        fadeUp   = '{2, 4, 6, 8, 8};
        fadeDown = '{6, 4, 4};
`else
        fadeUp   = '{8, 8, 8, 8, 8};
        fadeDown = '{4, 4, 4};
`endif
        reset = 1'b1;
        applyStimulus(1'b0, '0, 32'd0, '0);
        repeat (3) @(negedge clk);
        checkOutput("reset_pwm", {28'd0, pwm_out}, 32'hF);
        checkOutput("reset_rd", rd_data, 32'd0);
        reset = 1'b0;

        // Idle bank: outputs stay idle and boundaries come every 30 clocks.
        waitPeriodEnd(waitCount);
        waitPeriodEnd(waitCount);
        checkOutput("period_spacing", 32'(waitCount + 1), 32'd30);
        checkOutput("idle_pwm", {28'd0, pwm_out}, 32'hF);

        // Enable the bank and set channel 0 to duty 5.
        writeReg(3'd4, 32'd1);
        writeReg(3'd0, 32'd5);
        measurePeriod(1'b1);
        checkOutput("duty5_ch0", 32'(lowCnt[0]), 32'd10);
        checkOutput("duty5_ch1", 32'(lowCnt[1]), 32'd0);
        measurePeriod(1'b0);
        checkOutput("duty5_ch0_repeat", 32'(lowCnt[0]), 32'd10);

        // Check full duty and zero duty, then a mid-period duty change.
        writeReg(3'd1, 32'd15);
        writeReg(3'd2, 32'd0);
        measurePeriod(1'b1);
        checkOutput("full_ch1", 32'(lowCnt[1]), 32'd30);
        checkOutput("zero_ch2", 32'(lowCnt[2]), 32'd0);
        repeat (10) @(negedge clk);
        writeReg(3'd1, 32'd3);
        measurePeriod(1'b1);
        checkOutput("midwrite_ch1", 32'(lowCnt[1]), 32'd6);

        // A write landing on period_end waits one more boundary.
        waitPeriodEnd(waitCount);
        applyStimulus(1'b1, 3'd3, 32'd7, rd_addr);
        @(negedge clk);
        wr_en = 1'b0;
        measurePeriod(1'b0);
        checkOutput("coincident_old", 32'(lowCnt[3]), 32'd0);
        measurePeriod(1'b0);
        checkOutput("coincident_new", 32'(lowCnt[3]), 32'd14);
        rd_addr = 3'd3;
        @(negedge clk);
        checkOutput("read_target3", rd_data, 32'd7);
        rd_addr = 3'd6;
        @(negedge clk);
        checkOutput("read_unmapped", rd_data, 32'd0);
        writeReg(3'd4, 32'd3);
        rd_addr = 3'd4;
        @(negedge clk);
`ifdef LED_PWM_FADE_EN
        checkOutput("read_ctrl", rd_data, 32'd3);
`else
        checkOutput("read_ctrl", rd_data, 32'd1);
`endif

        // Fade: ramp channel 0 from 0 up to 4, then back down to 2.
        writeReg(3'd4, 32'd1);
        writeReg(3'd0, 32'd0);
        measurePeriod(1'b1);
        writeReg(3'd4, 32'd3);
        writeReg(3'd0, 32'd4);
        measurePeriod(1'b1);
        checkOutput("fade_up_0", 32'(lowCnt[0]), 32'(fadeUp[0]));
        for (int k = 1; k < 5; k++) begin
            measurePeriod(1'b0);
            checkOutput("fade_up", 32'(lowCnt[0]), 32'(fadeUp[k]));
        end
        writeReg(3'd0, 32'd2);
        measurePeriod(1'b1);
        checkOutput("fade_down_0", 32'(lowCnt[0]), 32'(fadeDown[0]));
        for (int k = 1; k < 3; k++) begin
            measurePeriod(1'b0);
            checkOutput("fade_down", 32'(lowCnt[0]), 32'(fadeDown[k]));
        end

        // Random bus traffic, checked cycle by cycle against the model.
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            applyStimulus($urandom_range(0, 5) == 0, ADDR_W'($urandom_range(0, 7)),
                          $urandom, ADDR_W'($urandom_range(0, 7)));
        end
        @(negedge clk);
        wr_en = 1'b0;

        // Assert reset asynchronously in the middle of a period while
        // channel 0 is lit.
        writeReg(3'd4, 32'd1);
        writeReg(3'd0, 32'd5);
        measurePeriod(1'b1);
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_lit", {31'd0, pwm_out[0]}, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_pwm", {28'd0, pwm_out}, 32'hF);
        checkOutput("async_reset_pe", {31'd0, period_end}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            rd_addr = ADDR_W'(a);
            @(negedge clk);
            checkOutput("post_reset_read", rd_data, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
